l3_fill_ctrl: RTL

//  MMU-side line-fill engine feeding the L3 n-way cache's block-fill port.
//  - Accepts one miss request at a time.
//  - Reads the line from RAM one word per handshake and assembles a full line.
//  - Drives fill_en/fill_addr/fill_data/fill_mark_valid into the L3 for one cycle.
//  - Returns the same line to the requester (L2/MMU).
//  - A per-word timeout aborts the fill without validating any cache line.

---
 rtl/l3_fill_ctrl_pkg.sv | 28 ++
 rtl/l3_fill_ctrl_if.sv | 48 ++++
 rtl/l3_fill_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/l3_fill_ctrl_pkg.sv
// Shared types and default geometry for the L3 line-fill controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package l3_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      FILL = 2'd2,
      ERR  = 2'd3
   } fill_state_t;

   // Default geometry; must match the L3 instance being filled.
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_LINE_SIZE  = 16;

   localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;
   localparam int WORDS_PER_LINE = DEF_LINE_SIZE / BYTES_PER_WORD;
   localparam int LINE_BITS      = DEF_LINE_SIZE * 8;
   localparam int OFFSET_BITS    = $clog2(DEF_LINE_SIZE);

   // Counter width that stays legal (>=1 bit) even for a count of 1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/l3_fill_ctrl_if.sv
// Bundles the miss request, RAM read, L3 fill and response signals.
// Latency: n/a (wiring only).
// Backpressure: miss_ready gates requests; RAM stalls via ram_ack.
// Modports:
//   slave  - the fill controller (consumes misses and RAM data, drives fill/resp)
//   master - the environment (requester, RAM and L3 side)
interface l3_fill_ctrl_if
   import l3_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LINE_SIZE  = DEF_LINE_SIZE
);
   // miss request
   logic                   miss_valid;
   logic                   miss_ready;
   logic [ADDR_WIDTH-1:0]  miss_addr;
   // RAM read port
   logic                   ram_rd_en;
   logic [ADDR_WIDTH-1:0]  ram_addr;
   logic                   ram_ack;
   logic [DATA_WIDTH-1:0]  ram_r_data;
   // L3 block-fill port
   logic                   fill_en;
   logic [ADDR_WIDTH-1:0]  fill_addr;
   logic [LINE_SIZE*8-1:0] fill_data;
   logic                   fill_mark_valid;
   // response to requester
   logic                   resp_valid;
   logic                   resp_err;
   logic [LINE_SIZE*8-1:0] resp_line;
   logic                   busy;

   modport slave (
      input  miss_valid, miss_addr, ram_ack, ram_r_data,
      output miss_ready, ram_rd_en, ram_addr,
      output fill_en, fill_addr, fill_data, fill_mark_valid,
      output resp_valid, resp_err, resp_line, busy
   );

   modport master (
      output miss_valid, miss_addr, ram_ack, ram_r_data,
      input  miss_ready, ram_rd_en, ram_addr,
      input  fill_en, fill_addr, fill_data, fill_mark_valid,
      input  resp_valid, resp_err, resp_line, busy
   );

endinterface

// File: rtl/l3_fill_ctrl.sv
// Line-fill engine: reads one cache line from RAM word by word, fills the L3, answers the requester.
// Latency: accept at edge T, FILL/resp in cycle T+WORDS with ack every cycle (+1 per RAM wait cycle).
// Backpressure: one miss at a time (miss_ready only in IDLE); RAM stalls via ram_ack, per-word timeout aborts.
// Ports:
//   i_clk    - clock, all state on rising edge
//   i_rst_n  - asynchronous active-low reset
//   io_bus   - l3_fill_ctrl_if.slave: miss request, RAM read, L3 fill, response, busy
module l3_fill_ctrl
   import l3_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int LINE_SIZE      = DEF_LINE_SIZE,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   l3_fill_ctrl_if.slave  io_bus
);

   localparam int BPW        = DATA_WIDTH / 8;
   localparam int WORDS      = LINE_SIZE / BPW;
   localparam int CNT_W      = cnt_width(WORDS);
   localparam int TMR_W      = cnt_width(TIMEOUT_CYCLES);
   localparam int WORD_SHIFT = $clog2(BPW);

   localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(LINE_SIZE - 1);
   localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(WORDS - 1);
   localparam logic [TMR_W-1:0]      TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

   fill_state_t                        r_state;
   fill_state_t                        w_state_nxt;
   logic [ADDR_WIDTH-1:0]              r_base;
   logic [CNT_W-1:0]                   r_word_cnt;
   logic [TMR_W-1:0]                   r_timer;
   logic [WORDS-1:0][DATA_WIDTH-1:0]   r_line;

   logic                               w_ack;
   logic                               w_last;
   logic                               w_tmo;
   logic [ADDR_WIDTH-1:0]              w_word_addr;

   // ram_ack only counts while a read is actually being requested.
   assign w_ack       = (r_state == READ) && io_bus.ram_ack;
   assign w_last      = (r_word_cnt == LAST_WORD);
   assign w_tmo       = (r_timer == TMO_LAST);
   assign w_word_addr = r_base + (ADDR_WIDTH'(r_word_cnt) << WORD_SHIFT);

   // ---------------- state register ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- next state and outputs ----------------
   // All outputs decode the registered state, so an async reset drops
   // every strobe (including ram_rd_en) without waiting for a clock.
   always_comb begin
      w_state_nxt            = r_state;
      io_bus.miss_ready      = 1'b0;
      io_bus.ram_rd_en       = 1'b0;
      io_bus.ram_addr        = '0;
      io_bus.fill_en         = 1'b0;
      io_bus.fill_addr       = '0;
      io_bus.fill_data       = '0;
      io_bus.fill_mark_valid = 1'b0;
      io_bus.resp_valid      = 1'b0;
      io_bus.resp_err        = 1'b0;
      io_bus.resp_line       = '0;
      io_bus.busy            = (r_state != IDLE);

      case (r_state)
         IDLE: begin
            io_bus.miss_ready = 1'b1;
            if (io_bus.miss_valid) begin
               w_state_nxt = READ;
            end
         end
         READ: begin
            io_bus.ram_rd_en = 1'b1;
            io_bus.ram_addr  = w_word_addr;
            if (w_ack && w_last) begin
               w_state_nxt = FILL;
            end else if (!w_ack && w_tmo) begin
               w_state_nxt = ERR;
            end
         end
         FILL: begin
            io_bus.fill_en         = 1'b1;
            io_bus.fill_mark_valid = 1'b1;
            io_bus.fill_addr       = r_base;
            io_bus.fill_data       = r_line;
            io_bus.resp_valid      = 1'b1;
            io_bus.resp_line       = r_line;
            w_state_nxt            = IDLE;
         end
         ERR: begin
            // Abort: the L3 never sees the partially assembled line.
            io_bus.resp_valid = 1'b1;
            io_bus.resp_err   = 1'b1;
            w_state_nxt       = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_base     <= '0;
         r_word_cnt <= '0;
         r_timer    <= '0;
         r_line     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (io_bus.miss_valid) begin
                  r_base     <= io_bus.miss_addr & ~OFF_MASK;
                  r_word_cnt <= '0;
                  r_timer    <= '0;
               end
            end
            READ: begin
               if (w_ack) begin
                  r_line[r_word_cnt] <= io_bus.ram_r_data;
                  r_timer            <= '0;
                  // Hold on the last word so the counter never wraps.
                  if (!w_last) begin
                     r_word_cnt <= r_word_cnt + 1'b1;
                  end
               end else if (!w_tmo) begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
